// File: rtl/oh_clockgate_pkg.sv
// Shared definitions for the automatic clock-gating controller: channel FSM
// encoding and counter-width helpers.
package oh_clockgate_pkg;

  typedef enum logic [1:0] {
    ST_WAKE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OFF  = 2'd2
  } cg_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  // A counter must be at least one bit wide, even when WAKE == 1.
  function automatic int wcnt_width(input int wake);
    return (clog2(wake) < 1) ? 1 : clog2(wake);
  endfunction

endpackage

// File: rtl/oh_clockgate.sv
// Glitch-free clock gate cell: a latch that is transparent while clk is low, then an AND.
// Zero latency on the clock path. An enable change takes effect on the next clk high phase.
module oh_clockgate (
  input  logic clk,
  input  logic te,
  input  logic en,
  output logic eclk
);

  logic en_lat;

  // en_lat is held closed during the high phase, so eclk never produces a runt pulse.
  always_latch begin
    if (!clk) begin
      en_lat = en | te;
    end
  end

  assign eclk = clk & en_lat;

endmodule

// File: rtl/oh_clockgate_auto_ch.sv
// One gating channel: WAKE/RUN/OFF FSM with an idle counter and a wake counter, on the free clock.
// en goes low at the edge ending the cfg_idle-th idle cycle. ready follows re-enable by WAKE edges.
module oh_clockgate_auto_ch
  import oh_clockgate_pkg::*;
#(
  parameter int CW   = 8,
  parameter int WAKE = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_force,
  input  logic          cfg_auto,
  input  logic [CW-1:0] cfg_idle,
  input  logic          busy,
  output logic          en,
  output logic          ready,
  output logic          gated
);

  localparam int            WW    = wcnt_width(WAKE);
  localparam logic [WW-1:0] WLAST = WW'(WAKE - 1);

  cg_state_e     state_q, state_d;
  logic          en_q, en_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;

  logic          idle_zero;
  logic          idle_ok;
  logic          wake_req;
  logic [CW:0]   cnt_inc;

  assign idle_zero = (cfg_idle == '0);
  assign idle_ok   = cfg_auto & ~cfg_force & ~busy & ~idle_zero;
  assign wake_req  = busy | cfg_force | ~cfg_auto | idle_zero;
  // The compare is one bit wider so that cnt == all-ones cannot wrap and miss the threshold.
  assign cnt_inc   = {1'b0, cnt_q} + (CW+1)'(1);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_WAKE: begin
        en_d  = 1'b1;
        cnt_d = '0;
        if (wcnt_q == WLAST) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      ST_RUN: begin
        en_d = 1'b1;
        if (!idle_ok) begin
          cnt_d = '0;
        end else if (cnt_inc >= {1'b0, cfg_idle}) begin
          state_d = ST_OFF;
          en_d    = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_OFF: begin
        en_d = 1'b0;
        if (wake_req) begin
          state_d = ST_WAKE;
          en_d    = 1'b1;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_WAKE;
        en_d    = 1'b1;
        cnt_d   = '0;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAKE;
      en_q    <= 1'b1;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign en    = en_q;
  assign ready = (state_q == ST_RUN);
  assign gated = (state_q == ST_OFF);

endmodule

// File: rtl/oh_clockgate_auto.sv
// N independent automatic clock-gating channels, each driving its own glitch-free gate cell.
// Gating happens at the cfg_idle-th idle edge. Waking takes 1 + WAKE edges from a busy request to ready.
module oh_clockgate_auto
  import oh_clockgate_pkg::*;
#(
  parameter int N    = 4,
  parameter int CW   = 8,
  parameter int WAKE = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          te,
  input  logic [N-1:0]  cfg_force,
  input  logic [N-1:0]  cfg_auto,
  input  logic [CW-1:0] cfg_idle,
  input  logic [N-1:0]  busy,
  output logic [N-1:0]  eclk,
  output logic [N-1:0]  ready,
  output logic [N-1:0]  gated
);

  logic [N-1:0] gate_en;

  for (genvar i = 0; i < N; i++) begin : g_ch
    oh_clockgate_auto_ch #(
      .CW   (CW),
      .WAKE (WAKE)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cfg_force (cfg_force[i]),
      .cfg_auto  (cfg_auto[i]),
      .cfg_idle  (cfg_idle),
      .busy      (busy[i]),
      .en        (gate_en[i]),
      .ready     (ready[i]),
      .gated     (gated[i])
    );

    oh_clockgate u_gate (
      .clk  (clk),
      .te   (te),
      .en   (gate_en[i]),
      .eclk (eclk[i])
    );
  end

endmodule

// File: tb/tb_oh_clockgate_auto.sv
// Directed and randomised checks of oh_clockgate_auto against a cycle-level behavioural model,
// plus literal expectations at the hand-computed edges.
module tb_oh_clockgate_auto;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int WAKE = 2;

  logic          clk;
  logic          reset;
  logic          te;
  logic [N-1:0]  cfg_force;
  logic [N-1:0]  cfg_auto;
  logic [CW-1:0] cfg_idle;
  logic [N-1:0]  busy;
  logic [N-1:0]  eclk;
  logic [N-1:0]  ready;
  logic [N-1:0]  gated;

  oh_clockgate_auto #(.N(N), .CW(CW), .WAKE(WAKE)) dut (
    .clk       (clk),
    .reset     (reset),
    .te        (te),
    .cfg_force (cfg_force),
    .cfg_auto  (cfg_auto),
    .cfg_idle  (cfg_idle),
    .busy      (busy),
    .eclk      (eclk),
    .ready     (ready),
    .gated     (gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: off = clock stopped; wake_left = edges still needed before ready; idle = consecutive idle edges.
  bit       off_m    [N];
  int       wake_m   [N];
  int       idle_m   [N];
  logic [N-1:0] lat_exp = '1;

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, required %b", nm, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !off_m[i] && (wake_m[i] == 0);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_gated();
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = off_m[i];
    return g;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        off_m[i]  = 1'b0;
        wake_m[i] = WAKE;
        idle_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (off_m[i]) begin
          if (busy[i] || cfg_force[i] || !cfg_auto[i] || cfg_idle == 0) begin
            off_m[i]  = 1'b0;
            wake_m[i] = WAKE;
          end
        end else if (wake_m[i] > 0) begin
          wake_m[i] = wake_m[i] - 1;
        end else if (cfg_auto[i] && !cfg_force[i] && !busy[i] && cfg_idle != 0) begin
          idle_m[i] = idle_m[i] + 1;
          if (idle_m[i] >= int'(cfg_idle)) begin
            off_m[i]  = 1'b1;
            idle_m[i] = 0;
          end
        end else begin
          idle_m[i] = 0;
        end
      end
    end
  end

  // Low phase: status outputs against the model, eclk must be low. Also record the enable the latch will hold.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < N; i++) lat_exp[i] = !off_m[i] || te;
    if (chk_en) begin
      check("ready_cyc", ready, exp_ready());
      check("gated_cyc", gated, exp_gated());
      check("eclk_low", eclk, '0);
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) check("eclk_high", eclk, lat_exp);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    te        = 1'b0;
    cfg_force = '0;
    cfg_auto  = '1;
    cfg_idle  = 8'd4;
    busy      = '1;
    #1 reset  = 1'b1;
    #1 chk_en = 1'b1;
    tick(3);
    reset = 1'b0;

    // Wake after reset: ready rises after exactly WAKE edges.
    tick(1);
    check("rst_ready_e1", ready, 4'h0);
    check("rst_gated_e1", gated, 4'h0);
    tick(1);
    check("rst_ready_e2", ready, 4'hF);

    // Four idle edges stop the clock. eclk gives one last pulse, then stays low.
    busy = '0;
    tick(3);
    check("idle3_gated", gated, 4'h0);
    tick(1);
    check("idle4_gated", gated, 4'hF);
    check("idle4_ready", ready, 4'h0);
    check("idle4_eclk_tail", eclk, 4'hF);
    tick(1);
    check("off_eclk", eclk, 4'h0);

    // A one-cycle busy wakes all channels. ready follows after 1 + WAKE edges.
    busy = '1;
    tick(1);
    busy = '0;
    check("wake_gated", gated, 4'h0);
    check("wake_eclk_e1", eclk, 4'h0);
    tick(1);
    check("wake_eclk_e2", eclk, 4'hF);
    check("wake_ready_e2", ready, 4'h0);
    tick(1);
    check("wake_ready_e3", ready, 4'hF);

    // A busy pulse on the 4th idle cycle restarts the count.
    tick(3);
    busy = '1;
    tick(1);
    busy = '0;
    check("pulse_gated", gated, 4'h0);
    tick(3);
    check("pulse_idle3", gated, 4'h0);
    tick(1);
    check("pulse_idle4", gated, 4'hF);

    // te forces every eclk on while the FSMs stay OFF.
    te = 1'b1;
    tick(1);
    check("te_eclk", eclk, 4'hF);
    check("te_gated", gated, 4'hF);
    check("te_ready", ready, 4'h0);
    te = 1'b0;
    tick(1);
    check("te_off_eclk", eclk, 4'h0);

    // Force keeps ch1 running while the other channels gate with cfg_idle = 2.
    busy = '1;
    tick(1);
    busy      = '0;
    cfg_force = 4'b0010;
    cfg_idle  = 8'd2;
    tick(2);
    check("force_ready_run", ready, 4'hF);
    tick(2);
    check("force_gated", gated, 4'b1101);
    check("force_ready", ready, 4'b0010);

    // Asynchronous reset while channels are OFF takes effect immediately.
    reset = 1'b1;
    #1;
    check("areset_ready", ready, 4'h0);
    check("areset_gated", gated, 4'h0);
    tick(1);
    check("areset_eclk", eclk, 4'hF);
    reset     = 1'b0;
    cfg_force = '0;
    busy      = '1;
    tick(2);
    check("rerun_ready", ready, 4'hF);

    // cfg_idle = 1 gates after a single idle edge.
    busy     = '0;
    cfg_idle = 8'd1;
    tick(1);
    check("idle1_gated", gated, 4'hF);

    // cfg_idle = 0 wakes the channels and disables gating.
    cfg_idle = 8'd0;
    tick(3);
    check("idle0_ready", ready, 4'hF);
    tick(10);
    check("idle0_gated", gated, 4'h0);

    // Lowering the threshold below the running count gates at the next idle edge.
    cfg_idle = 8'd10;
    tick(6);
    check("lower_pre", gated, 4'h0);
    cfg_idle = 8'd3;
    tick(1);
    check("lower_post", gated, 4'hF);

    // An all-ones threshold counts to the top without wrapping.
    busy = '1;
    tick(1);
    busy     = '0;
    cfg_idle = 8'hFF;
    tick(2);
    tick(254);
    check("sat_254", gated, 4'h0);
    tick(1);
    check("sat_255", gated, 4'hF);

    // Mixed auto enables and random activity, checked against the model every cycle.
    cfg_auto = 4'b0101;
    cfg_idle = 8'd2;
    busy     = '1;
    tick(4);
    busy = '0;
    tick(6);
    check("auto_mask_gated", gated, 4'b0101);
    for (int k = 0; k < 80; k++) begin
      busy      = 4'($urandom) & 4'($urandom);
      cfg_force = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cfg_auto  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      cfg_idle  = 8'($urandom_range(0, 5));
      te        = ($urandom_range(0, 7) == 0);
      tick($urandom_range(1, 8));
    end
    te = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oh_clockgate_auto.md
Name: oh_clockgate_auto

Overview:
- N-channel automatic clock-gating controller.
- Each channel watches a busy/activity input and runs a small FSM. After a programmable number of consecutive idle cycles it shuts its gated clock off, and it re-enables the clock on demand.
- A `ready` indication follows a fixed wake-up latency.
- Sits between block-level activity signals and per-block gated clock trees. Replaces hand-driven enables on the low-power clock gate cells.

Parameters:
- N, 4, number of independent gated-clock channels.
- CW, 8, width of the idle counter and threshold.
- WAKE, 2, cycles from clock re-enable to `ready` assertion (must be >= 1).

Ports:
- clk  input  1  free-running source clock.
- reset  input  1  asynchronous active-high reset.
- te  input  1  test enable; forces every eclk running, does not affect FSMs.
- cfg_force  input  N  per-channel force-on; channel never gates while set.
- cfg_auto  input  N  per-channel auto-gating enable.
- cfg_idle  input  CW  idle threshold shared by all channels; 0 disables auto-gating.
- busy  input  N  per-channel activity; 1 = channel needs its clock.
- eclk  output  N  gated clocks.
- ready  output  N  1 = channel clock running and stable.
- gated  output  N  1 = channel clock currently shut off (status).

Behaviour:
- Per-channel states: WAKE, RUN, OFF. Per-channel regs: state, en_q (flop), idle counter cnt[CW-1:0], wake counter wcnt.
- Gate path: eclk[i] = clk AND latch-low-transparent(en_q[i] | te).
  - en_q changes only on rising clk, so the enable is stable while clk is high. No glitches.
- Reset (async, any time including mid-wake or while OFF):
  - state=WAKE, en_q=1, cnt=0, wcnt=0, ready=0, gated=0.
  - The clock runs during reset.
- WAKE:
  - en_q=1, ready=0, gated=0.
  - wcnt increments each cycle.
  - When wcnt==WAKE-1, the next edge goes to RUN and ready=1.
  - busy is ignored (already waking).
  - After reset release, ready rises exactly WAKE edges later.
- RUN:
  - en_q=1, ready=1.
  - Gating condition idle_ok = cfg_auto[i] & ~cfg_force[i] & ~busy[i] & (cfg_idle!=0).
  - If idle_ok=0: cnt cleared to 0.
  - If idle_ok=1 and cnt+1 >= cfg_idle: next edge goes to OFF with en_q=0, ready=0, gated=1, cnt=0.
  - Otherwise cnt increments, saturating at all-ones.
  - Net effect: the clock stops at the edge ending the cfg_idle-th consecutive idle cycle.
- OFF:
  - en_q=0, ready=0, gated=1.
  - If busy | cfg_force | ~cfg_auto | (cfg_idle==0): next edge goes to WAKE with en_q=1, gated=0, wcnt=0.
  - The controller runs on clk, not eclk, so wake detection never depends on the gated clock.
- Boundary and simultaneous cases:
  - busy asserted in the same cycle the threshold would be reached: busy wins, stay RUN, cnt=0.
  - cfg_idle lowered below the current cnt: the >= compare gates at the next idle edge.
  - cfg_idle==1: gate after a single idle cycle.
  - cfg_idle all-ones: cnt saturates; no wrap-around.
- te=1: eclk toggles for all channels. ready/gated still reflect the FSM.
- Channels are fully independent; no arbitration.
- Wake latency, busy rising while OFF to ready: 1 + WAKE edges.

Decomposition:
- Shared package oh_clockgate_pkg: state encodings ST_WAKE/ST_RUN/ST_OFF (2-bit) and the WAKE counter width function clog2.
- Top generates N copies of a per-channel sub-module oh_clockgate_auto_ch (FSM, counters, en_q flop). Each copy feeds one existing oh_clockgate instance (en=en_q, te=te).

Test Plan:
- Reset release, WAKE=2, busy=1 -> ready=0 for 2 edges, then ready=1. eclk toggles throughout. gated=0.
- RUN, cfg_auto=1, cfg_idle=4, busy drops -> en_q/ready fall at the 4th idle edge. eclk low from next clk high onward. gated=1.
- Idle 3 cycles, busy pulse on the 4th, cfg_idle=4 -> stays RUN, cnt reset. Gating then occurs 4 idle cycles after the pulse.
- OFF, busy=1 for one cycle -> eclk resumes on the next clock. ready=1 after 1+WAKE=3 edges. No eclk glitch or runt pulse on any channel.
- OFF with te=1 -> eclk toggles while gated=1, ready=0. te=0 -> eclk stops cleanly on low phase.
- cfg_force[1]=1, other channels idle, cfg_idle=2 -> ch1 stays RUN, others gate. Assert reset while ch0 OFF -> ch0 immediately WAKE, eclk running, ready=0.
